// File: rtl/usr_shift_sequencer.sv
// Command sequencer for the 4-bit universal shift register.
// Takes one command at a time over valid/ready (load, shift right,
// shift left, rotate right by N) and plays it out one register step
// per cycle, then pulses done for a single cycle.

module usr_shift_sequencer #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [CNT_W-1:0] cmd_count,
  input  logic [WIDTH-1:0] cmd_data,
  input  logic             sr_msb_out,
  input  logic             sr_lsb_out,
  output logic             s1,
  output logic             s0,
  output logic [WIDTH-1:0] sr_data,
  output logic             msb_in,
  output logic             lsb_in,
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam logic [1:0] OP_LOAD = 2'd0;
  localparam logic [1:0] OP_SHR  = 2'd1;
  localparam logic [1:0] OP_SHL  = 2'd2;
  localparam logic [1:0] OP_ROR  = 2'd3;

  // The count path is one bit wider than the command field so the clamp
  // to WIDTH and the step increment can never wrap.
  localparam logic [CNT_W:0] WIDTH_CNT = (CNT_W + 1)'(WIDTH);
  localparam logic [CNT_W:0] ONE_CNT   = (CNT_W + 1)'(1);

  state_t           state_q, state_d;
  logic [1:0]       op_q, op_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic [CNT_W:0]   cnt_q, cnt_d;
  logic [CNT_W:0]   step_q, step_d;
  logic [1:0]       mode_q, mode_d;
  logic [WIDTH-1:0] sr_data_q, sr_data_d;
  logic             msb_fill_q, msb_fill_d;
  logic             lsb_fill_q, lsb_fill_d;
  logic             rot_q, rot_d;

  logic             accept;
  logic [CNT_W:0]   count_ext;
  logic [CNT_W:0]   eff_cnt;
  logic [CNT_W:0]   step_next;
  logic             drive_step;
  logic [1:0]       sel_op;
  logic [WIDTH-1:0] sel_data;
  logic [CNT_W:0]   sel_step;
  logic [WIDTH-1:0] shifted;
  logic             fill_bit;

  // The register MSB is not needed for any supported command; the
  // rotate only ever recirculates the LSB.
  logic unused_sr_msb;
  assign unused_sr_msb = sr_msb_out;

  // Handshake and the effective step count: load is always one step,
  // shifts and rotates are clamped to the register width.
  always_comb begin
    accept    = cmd_valid & cmd_ready;
    count_ext = {1'b0, cmd_count};
    eff_cnt   = count_ext;
    if (cmd_op == OP_LOAD) begin
      eff_cnt = ONE_CNT;
    end else if (count_ext > WIDTH_CNT) begin
      eff_cnt = WIDTH_CNT;
    end
  end

  // Next-state logic; register drive values are computed one cycle ahead
  // so they come straight out of flops during RUN.
  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    data_d     = data_q;
    cnt_d      = cnt_q;
    step_d     = step_q;
    mode_d     = 2'b00;
    sr_data_d  = sr_data_q;
    msb_fill_d = 1'b0;
    lsb_fill_d = 1'b0;
    rot_d      = 1'b0;
    step_next  = step_q + ONE_CNT;
    drive_step = 1'b0;
    sel_op     = op_q;
    sel_data   = data_q;
    sel_step   = step_q;

    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          op_d   = cmd_op;
          data_d = cmd_data;
          cnt_d  = eff_cnt;
          step_d = '0;
          if (eff_cnt == '0) begin
            state_d = ST_DONE;
          end else begin
            state_d    = ST_RUN;
            drive_step = 1'b1;
            sel_op     = cmd_op;
            sel_data   = cmd_data;
            sel_step   = '0;
          end
        end
      end
      ST_RUN: begin
        if (step_next >= cnt_q) begin
          state_d = ST_DONE;
        end else begin
          step_d     = step_next;
          drive_step = 1'b1;
          sel_step   = step_next;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    shifted  = sel_data >> sel_step;
    fill_bit = shifted[0];

    if (drive_step) begin
      case (sel_op)
        OP_LOAD: begin
          mode_d    = 2'b11;
          sr_data_d = sel_data;
        end
        OP_SHR: begin
          mode_d     = 2'b01;
          msb_fill_d = fill_bit;
        end
        OP_SHL: begin
          mode_d     = 2'b10;
          lsb_fill_d = fill_bit;
        end
        default: begin
          mode_d = 2'b01;
          rot_d  = 1'b1;
        end
      endcase
    end
  end

  // Single state register for the FSM and its registered outputs;
  // synchronous active-low reset drops any command in flight.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= ST_IDLE;
      op_q       <= OP_LOAD;
      data_q     <= '0;
      cnt_q      <= '0;
      step_q     <= '0;
      mode_q     <= 2'b00;
      sr_data_q  <= '0;
      msb_fill_q <= 1'b0;
      lsb_fill_q <= 1'b0;
      rot_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      data_q     <= data_d;
      cnt_q      <= cnt_d;
      step_q     <= step_d;
      mode_q     <= mode_d;
      sr_data_q  <= sr_data_d;
      msb_fill_q <= msb_fill_d;
      lsb_fill_q <= lsb_fill_d;
      rot_q      <= rot_d;
    end
  end

  // Outputs are forced quiet while rst is low so the shift register
  // never sees a stale step during the resetting edge. The rotate bit
  // passes sr_lsb_out straight through to track the live register value.
  assign cmd_ready = (state_q == ST_IDLE) & rst;
  assign s1        = mode_q[1] & rst;
  assign s0        = mode_q[0] & rst;
  assign sr_data   = sr_data_q & {WIDTH{rst}};
  assign msb_in    = rst & (rot_q ? sr_lsb_out : msb_fill_q);
  assign lsb_in    = lsb_fill_q & rst;
  assign busy      = rst & (state_q != ST_IDLE);
  assign done      = rst & (state_q == ST_DONE);

endmodule

// File: tb/tb_usr_shift_sequencer.sv
// Bench for usr_shift_sequencer: a behavioural 4-bit universal shift
// register is wired behind the sequencer, and directed commands are
// checked against hand-computed cycle-by-cycle expectations.

module tb_usr_shift_sequencer;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic [1:0] cmd_op = 2'd0;
  logic [3:0] cmd_count = 4'd0;
  logic [3:0] cmd_data = 4'd0;
  logic       sr_msb_out;
  logic       sr_lsb_out;
  logic       s1;
  logic       s0;
  logic [3:0] sr_data;
  logic       msb_in;
  logic       lsb_in;
  logic       busy;
  logic       done;

  int errors = 0;
  int checks = 0;

  logic [3:0] sr_reg = 4'b0000;

  logic [1:0] cap_mode  [1:10];
  logic [3:0] cap_data  [1:10];
  logic       cap_msb   [1:10];
  logic       cap_lsb   [1:10];
  logic       cap_done  [1:10];
  logic       cap_ready [1:10];
  logic       cap_busy  [1:10];

  usr_shift_sequencer #(.WIDTH(4), .CNT_W(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_op     (cmd_op),
    .cmd_count  (cmd_count),
    .cmd_data   (cmd_data),
    .sr_msb_out (sr_msb_out),
    .sr_lsb_out (sr_lsb_out),
    .s1         (s1),
    .s0         (s0),
    .sr_data    (sr_data),
    .msb_in     (msb_in),
    .lsb_in     (lsb_in),
    .busy       (busy),
    .done       (done)
  );

  // Free-running clock, 10 time units per period.
  always #5 clk = ~clk;

  // Behavioural universal shift register driven by the sequencer.
  always @(posedge clk) begin
    case ({s1, s0})
      2'b01:   sr_reg <= {msb_in, sr_reg[3:1]};
      2'b10:   sr_reg <= {sr_reg[2:0], lsb_in};
      2'b11:   sr_reg <= sr_data;
      default: sr_reg <= sr_reg;
    endcase
  end

  assign sr_msb_out = sr_reg[3];
  assign sr_lsb_out = sr_reg[0];

  // Advance one clock and settle just past the edge.
  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Present a command on the handshake.
  task automatic drive_cmd(input logic [1:0] op, input logic [3:0] cnt,
                           input logic [3:0] data);
    cmd_op    = op;
    cmd_count = cnt;
    cmd_data  = data;
    cmd_valid = 1'b1;
  endtask

  // Record n cycles of outputs, cycle 1 being the first after accept.
  task automatic capture(input int n);
    for (int i = 1; i <= n; i++) begin
      cap_mode[i]  = {s1, s0};
      cap_data[i]  = sr_data;
      cap_msb[i]   = msb_in;
      cap_lsb[i]   = lsb_in;
      cap_done[i]  = done;
      cap_ready[i] = cmd_ready;
      cap_busy[i]  = busy;
      tick();
    end
  endtask

  // Load a known register value as setup for a later scenario.
  task automatic preload(input logic [3:0] value);
    drive_cmd(2'd0, 4'd1, value);
    tick();
    cmd_valid = 1'b0;
    capture(3);
  endtask

  task automatic test_reset;
    logic [11:0] quiet;
    rst = 1'b0;
    drive_cmd(2'd0, 4'd1, 4'hF);
    for (int c = 0; c < 3; c++) begin
      tick();
      quiet = {s1, s0, sr_data, msb_in, lsb_in, busy, done, cmd_ready, 1'b0};
      checks++;
      if (quiet !== 12'd0) begin
        errors++;
        $display("[TB] FAIL reset_outputs cycle %0d: got %b expected 0", c, quiet);
      end
    end
    checks++;
    if (sr_reg !== 4'b0000) begin
      errors++;
      $display("[TB] FAIL reset_no_accept: got reg %b expected 0000", sr_reg);
    end
    cmd_valid = 1'b0;
    rst = 1'b1;
    #1;
    checks++;
    if (cmd_ready !== 1'b1) begin
      errors++;
      $display("[TB] FAIL reset_release_ready: got %b expected 1", cmd_ready);
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_release_busy: got %b expected 0", busy);
    end
  endtask

  task automatic test_load;
    int loads;
    drive_cmd(2'd0, 4'd9, 4'b1011);
    checks++;
    if (cmd_ready !== 1'b1) begin
      errors++;
      $display("[TB] FAIL load_ready: got %b expected 1", cmd_ready);
    end
    tick();
    cmd_valid = 1'b0;
    capture(6);
    loads = 0;
    for (int i = 1; i <= 6; i++) if (cap_mode[i] != 2'b00) loads++;
    checks++;
    if (loads != 1) begin
      errors++;
      $display("[TB] FAIL load_active_cycles: got %0d expected 1", loads);
    end
    checks++;
    if (cap_mode[1] !== 2'b11 || cap_data[1] !== 4'b1011) begin
      errors++;
      $display("[TB] FAIL load_drive: got mode %b data %b expected 11 1011",
               cap_mode[1], cap_data[1]);
    end
    checks++;
    if (cap_done[1] !== 1'b0 || cap_done[2] !== 1'b1 || cap_done[3] !== 1'b0) begin
      errors++;
      $display("[TB] FAIL load_done: got %b%b%b expected 010",
               cap_done[1], cap_done[2], cap_done[3]);
    end
    checks++;
    if (cap_ready[2] !== 1'b0 || cap_ready[3] !== 1'b1) begin
      errors++;
      $display("[TB] FAIL load_ready_return: got %b%b expected 01",
               cap_ready[2], cap_ready[3]);
    end
    checks++;
    if (cap_data[4] !== 4'b1011) begin
      errors++;
      $display("[TB] FAIL load_data_hold: got %b expected 1011", cap_data[4]);
    end
    checks++;
    if (sr_reg !== 4'b1011) begin
      errors++;
      $display("[TB] FAIL load_reg: got %b expected 1011", sr_reg);
    end
  endtask

  task automatic test_shift_right;
    logic [2:0] msb_seq;
    logic [3:0] modes_ok;
    preload(4'b0000);
    drive_cmd(2'd1, 4'd3, 4'b0101);
    tick();
    cmd_valid = 1'b0;
    capture(6);
    modes_ok = {cap_mode[1] == 2'b01, cap_mode[2] == 2'b01,
                cap_mode[3] == 2'b01, cap_mode[4] == 2'b00};
    checks++;
    if (modes_ok !== 4'b1111) begin
      errors++;
      $display("[TB] FAIL shr_modes: got %b %b %b %b expected 01 01 01 00",
               cap_mode[1], cap_mode[2], cap_mode[3], cap_mode[4]);
    end
    msb_seq = {cap_msb[1], cap_msb[2], cap_msb[3]};
    checks++;
    if (msb_seq !== 3'b101) begin
      errors++;
      $display("[TB] FAIL shr_msb_in: got %b expected 101", msb_seq);
    end
    checks++;
    if (cap_lsb[1] !== 1'b0 || cap_lsb[3] !== 1'b0) begin
      errors++;
      $display("[TB] FAIL shr_lsb_quiet: got %b%b expected 00", cap_lsb[1], cap_lsb[3]);
    end
    checks++;
    if (cap_done[3] !== 1'b0 || cap_done[4] !== 1'b1) begin
      errors++;
      $display("[TB] FAIL shr_done: got %b%b expected 01", cap_done[3], cap_done[4]);
    end
    checks++;
    if (sr_reg !== 4'b1010) begin
      errors++;
      $display("[TB] FAIL shr_reg: got %b expected 1010", sr_reg);
    end
  endtask

  task automatic test_rotate;
    logic [3:0] msb_seq;
    int steps;
    preload(4'b0001);
    drive_cmd(2'd3, 4'd1, 4'b0000);
    tick();
    cmd_valid = 1'b0;
    capture(4);
    checks++;
    if (cap_mode[1] !== 2'b01 || cap_msb[1] !== 1'b1) begin
      errors++;
      $display("[TB] FAIL ror1_drive: got mode %b msb %b expected 01 1",
               cap_mode[1], cap_msb[1]);
    end
    checks++;
    if (cap_done[2] !== 1'b1 || sr_reg !== 4'b1000) begin
      errors++;
      $display("[TB] FAIL ror1_result: got done %b reg %b expected 1 1000",
               cap_done[2], sr_reg);
    end
    preload(4'b0001);
    drive_cmd(2'd3, 4'd15, 4'b0000);
    tick();
    cmd_valid = 1'b0;
    capture(7);
    steps = 0;
    for (int i = 1; i <= 7; i++) if (cap_mode[i] == 2'b01) steps++;
    checks++;
    if (steps != 4) begin
      errors++;
      $display("[TB] FAIL ror15_steps: got %0d expected 4", steps);
    end
    msb_seq = {cap_msb[1], cap_msb[2], cap_msb[3], cap_msb[4]};
    checks++;
    if (msb_seq !== 4'b1000) begin
      errors++;
      $display("[TB] FAIL ror15_msb_in: got %b expected 1000", msb_seq);
    end
    checks++;
    if (cap_done[5] !== 1'b1 || sr_reg !== 4'b0001) begin
      errors++;
      $display("[TB] FAIL ror15_result: got done %b reg %b expected 1 0001",
               cap_done[5], sr_reg);
    end
  endtask

  task automatic test_zero_count;
    int active;
    drive_cmd(2'd2, 4'd0, 4'b1111);
    tick();
    cmd_valid = 1'b0;
    capture(4);
    active = 0;
    for (int i = 1; i <= 4; i++) if (cap_mode[i] != 2'b00 || cap_lsb[i] != 1'b0) active++;
    checks++;
    if (active != 0) begin
      errors++;
      $display("[TB] FAIL zero_active_cycles: got %0d expected 0", active);
    end
    checks++;
    if (cap_done[1] !== 1'b1 || cap_busy[1] !== 1'b1 || cap_done[2] !== 1'b0) begin
      errors++;
      $display("[TB] FAIL zero_done: got done %b%b busy %b expected 10 1",
               cap_done[1], cap_done[2], cap_busy[1]);
    end
    checks++;
    if (cap_ready[1] !== 1'b0 || cap_ready[2] !== 1'b1) begin
      errors++;
      $display("[TB] FAIL zero_ready: got %b%b expected 01", cap_ready[1], cap_ready[2]);
    end
    checks++;
    if (sr_reg !== 4'b0001) begin
      errors++;
      $display("[TB] FAIL zero_reg: got %b expected 0001", sr_reg);
    end
  endtask

  task automatic test_reset_mid_run;
    drive_cmd(2'd2, 4'd4, 4'b0011);
    tick();
    cmd_valid = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    #1;
    checks++;
    if ({s1, s0} !== 2'b00 || done !== 1'b0) begin
      errors++;
      $display("[TB] FAIL midrst_quiet: got mode %b done %b expected 00 0", {s1, s0}, done);
    end
    tick();
    checks++;
    if ({s1, s0, busy, done} !== 4'b0000) begin
      errors++;
      $display("[TB] FAIL midrst_after_edge: got %b expected 0000", {s1, s0, busy, done});
    end
    checks++;
    if (sr_reg !== 4'b0111) begin
      errors++;
      $display("[TB] FAIL midrst_reg: got %b expected 0111", sr_reg);
    end
    rst = 1'b1;
    #1;
    checks++;
    if (cmd_ready !== 1'b1 || done !== 1'b0) begin
      errors++;
      $display("[TB] FAIL midrst_release: got ready %b done %b expected 1 0", cmd_ready, done);
    end
    drive_cmd(2'd0, 4'd0, 4'b1100);
    tick();
    cmd_valid = 1'b0;
    capture(4);
    checks++;
    if (cap_mode[1] !== 2'b11 || cap_done[2] !== 1'b1 || sr_reg !== 4'b1100) begin
      errors++;
      $display("[TB] FAIL midrst_new_cmd: got mode %b done %b reg %b expected 11 1 1100",
               cap_mode[1], cap_done[2], sr_reg);
    end
  endtask

  task automatic test_back_to_back;
    int acc_cycle;
    int loads;
    drive_cmd(2'd1, 4'd1, 4'b0001);
    tick();
    drive_cmd(2'd0, 4'd0, 4'b0110);
    acc_cycle = 0;
    for (int i = 1; i <= 8; i++) begin
      cap_mode[i]  = {s1, s0};
      cap_data[i]  = sr_data;
      cap_msb[i]   = msb_in;
      cap_done[i]  = done;
      cap_ready[i] = cmd_ready;
      if (cmd_valid && cmd_ready) begin
        acc_cycle = i;
        tick();
        cmd_valid = 1'b0;
      end else begin
        tick();
      end
    end
    cmd_valid = 1'b0;
    checks++;
    if (cap_mode[1] !== 2'b01 || cap_msb[1] !== 1'b1 || cap_done[2] !== 1'b1) begin
      errors++;
      $display("[TB] FAIL b2b_first: got mode %b msb %b done %b expected 01 1 1",
               cap_mode[1], cap_msb[1], cap_done[2]);
    end
    checks++;
    if (acc_cycle != 3 || cap_ready[2] !== 1'b0) begin
      errors++;
      $display("[TB] FAIL b2b_accept_cycle: got %0d ready2 %b expected 3 0",
               acc_cycle, cap_ready[2]);
    end
    loads = 0;
    for (int i = 1; i <= 8; i++) if (cap_mode[i] == 2'b11) loads++;
    checks++;
    if (loads != 1 || cap_mode[4] !== 2'b11 || cap_data[4] !== 4'b0110) begin
      errors++;
      $display("[TB] FAIL b2b_second: got loads %0d mode %b data %b expected 1 11 0110",
               loads, cap_mode[4], cap_data[4]);
    end
    checks++;
    if (cap_done[5] !== 1'b1 || sr_reg !== 4'b0110) begin
      errors++;
      $display("[TB] FAIL b2b_result: got done %b reg %b expected 1 0110", cap_done[5], sr_reg);
    end
  endtask

  // Scenario sequence followed by the single summary line.
  initial begin
    test_reset();
    test_load();
    test_shift_right();
    test_rotate();
    test_zero_count();
    test_reset_mid_run();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
